// File: rtl/piso_frame_serializer.sv
// MSB-first framing serializer with valid/ready load and frame strobes.
// Optional even-parity trailer bit enabled by defining SERIALIZER_PARITY_EN.
module piso_frame_serializer #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             accept;
  logic             sout_n, sout_valid_n, frame_start_n, frame_end_n;
`ifdef SERIALIZER_PARITY_EN
  logic             par, par_n;
`endif

  // Ready in idle and in the final bit cycle so frames can abut with no gap.
  always_comb begin
    load_ready = 1'b0;
    if (!rst) begin
`ifdef SERIALIZER_PARITY_EN
      load_ready = (state == IDLE) || (state == PARITY);
`else
      load_ready = (state == IDLE) || ((state == SHIFT) && (cnt == '0));
`endif
    end
  end

  assign accept = load_valid & load_ready;

  // State, counter, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      busy        <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      shreg       <= shreg_n;
      sout        <= sout_n;
      sout_valid  <= sout_valid_n;
      frame_start <= frame_start_n;
      frame_end   <= frame_end_n;
      busy        <= sout_valid_n;
`ifdef SERIALIZER_PARITY_EN
      par         <= par_n;
`endif
    end
  end

  // Next-state: load on accept, otherwise shift down toward the frame end.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
`ifdef SERIALIZER_PARITY_EN
    par_n   = par;
`endif
    case (state)
      SHIFT: begin
        shreg_n = {shreg[WIDTH-2:0], 1'b0};
        cnt_n   = CW'(cnt - 1'b1);
        if (cnt == '0) begin
          cnt_n = '0;
`ifdef SERIALIZER_PARITY_EN
          state_n = PARITY;
`else
          state_n = IDLE;
`endif
        end
      end
      PARITY: begin
        state_n = IDLE;
        shreg_n = '0;
      end
      default: state_n = IDLE;
    endcase
    if (accept) begin
      state_n = SHIFT;
      cnt_n   = CW'(WIDTH - 1);
      shreg_n = din;
`ifdef SERIALIZER_PARITY_EN
      par_n   = ^din;
`endif
    end
  end

  // Output next-values, derived from where the FSM goes at this edge.
  always_comb begin
    sout_valid_n  = (state_n != IDLE);
    frame_start_n = accept;
    sout_n        = shreg_n[WIDTH-1];
`ifdef SERIALIZER_PARITY_EN
    if (state_n == PARITY) sout_n = par;
    frame_end_n   = (state_n == PARITY);
`else
    frame_end_n   = (state_n == SHIFT) && (cnt_n == '0);
`endif
  end

endmodule
